generic_slave_spi: RTL and testbench
====================================

// Module: generic_slave_spi
// PURPOSE
//  SPI slave (responder): the far-end counterpart of the Generic_MasterSPI initiator.
//  Oversamples SCLK/SS/MOSI with the system clock, supports all 4 CPOL/CPHA modes and both bit orders.
//  Presents each received word with a one-cycle WordFlg and returns a preloaded word on MISO.
//  Sits on the FPGA peripheral side, facing an external or on-chip SPI master.
// PARAMETERS
//  WordLen     8   bits per SPI word (>=2)
//  SyncStages  2   flops in each pin synchronizer (>=2)
// PORTS
//  clk           in   1        system clock; SysClk >= 8 x SCLK freq
//  reset         in   1        synchronous, active-high
//  CPOL          in   1        SCLK idle level
//  CPHA          in   1        0: sample on leading edge; 1: sample on trailing edge
//  Endianess     in   1        0: MSB first; 1: LSB first (both directions)
//  SCLK          in   1        serial clock from master (async)
//  SS            in   1        slave select, active-low (async)
//  MOSI          in   1        serial data in (async)
//  MISO          out  1        serial data out
//  MISOEn        out  1        1 while selected; drives the pad tri-state enable
//  SendData      in   WordLen  next word to transmit
//  SendLoad      in   1        write SendData into the tx holding register
//  TxReady       out  1        holding register empty; SendLoad accepted only when 1
//  ReceivedData  out  WordLen  last complete received word
//  WordFlg       out  1        1-cycle pulse: ReceivedData updated
//  Busy          out  1        1 in ACTIVE
//  Underrun      out  1        1-cycle pulse: word started with empty holding register
// BEHAVIOUR
//  Reset: MISO=0, MISOEn=0, TxReady=1, ReceivedData=0, WordFlg=0, Busy=0, Underrun=0; FSM=IDLE; counters and regs 0.
//  Sync: SCLK, SS, MOSI each pass SyncStages flops, plus one history flop on SCLK/SS for edge detect.
//  An SCLK pin edge acts on the clk edge exactly SyncStages+1 edges later.
//  Edges: leading = sync SCLK leaving CPOL, trailing = returning to CPOL.
//  Sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
//  CPOL/CPHA/Endianess are captured on SS fall; changes during ACTIVE are ignored.
//  FSM IDLE: MISOEn=0, MISO=0. Sync SS fall -> ACTIVE; load tx shift reg from holding reg
//   (TxReady<=1) or all-zeros with Underrun pulse if empty; bitcnt<=0.
//  ACTIVE: MISOEn=1. MISO = shift-reg MSB (Endianess=0) or LSB (Endianess=1).
//   CPHA=0: first bit valid from SS fall. CPHA=1: first bit presented on the first shift edge
//   (the first leading edge); no shift on it.
//   Sample edge: MOSI shifted into rx reg in chosen order; bitcnt++.
//   When bitcnt reaches WordLen-1 on a sample edge: ReceivedData<=completed word, WordFlg=1 next cycle,
//   bitcnt<=0, tx shift reg reloaded from holding reg (or zeros + Underrun); MISO switches on next shift edge.
//  Sync SS rise in ACTIVE -> IDLE: partial word discarded, no WordFlg, bitcnt<=0; holding reg kept.
//  SendLoad with TxReady=0: ignored, holding reg unchanged.
//  SendLoad on the same cycle as a reload: the reload takes the old content and the new word is stored
//   (TxReady stays 0).
//  SCLK edges while SS high are ignored. Reset mid-word overrides everything and returns to reset values.
// STRUCTURE
//  Package spi_pkg: FSM state encoding (IDLE, ACTIVE), MSB_FIRST/LSB_FIRST constants, shared with master.
//  Sub-module spi_sync_edge (synchronizer + rise/fall detect, param SyncStages),
//   instantiated for SCLK and SS; MOSI uses its synchronizer only.
// TESTING (SysClk 100 MHz, SCLK 10 MHz, WordLen 8)
//  1 Mode 0, Endianess=0, load 0x3C, master sends 0xA5 -> ReceivedData=0xA5, single WordFlg, MISO bits 0,0,1,1,1,1,0,0.
//  2 Mode 3, Endianess=1, load 0x7E, master sends 0x81 -> ReceivedData=0x81, MISO bits LSB first 0,1,1,1,1,1,1,0.
//  3 Modes 1 and 2, two words with SS held low, second SendLoad mid-word-1 -> 2 WordFlg pulses,
//    both words correct, TxReady low between load and reload.
//  4 No SendLoad, SS low, 8 clocks -> MISO all 0, one Underrun pulse at SS fall, ReceivedData still updated.
//  5 SS rises after 3 bits, then full word 0x5A -> no WordFlg for fragment, ReceivedData=0x5A.
//  6 reset high for 1 clk at bit 4 -> all outputs at reset values the next cycle; the next full word is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and bit-order constants,
// common to the slave here and the matching master.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/generic_slave_spi_if.sv
// Pin, configuration and host-side handshake bundle of the SPI slave.
interface generic_slave_spi_if #(
  parameter int unsigned WordLen = 8
);
  logic               CPOL;
  logic               CPHA;
  logic               Endianess;
  logic               SCLK;
  logic               SS;
  logic               MOSI;
  logic               MISO;
  logic               MISOEn;
  logic [WordLen-1:0] SendData;
  logic               SendLoad;
  logic               TxReady;
  logic [WordLen-1:0] ReceivedData;
  logic               WordFlg;
  logic               Busy;
  logic               Underrun;

  modport slave (
    input  CPOL, CPHA, Endianess, SCLK, SS, MOSI, SendData, SendLoad,
    output MISO, MISOEn, TxReady, ReceivedData, WordFlg, Busy, Underrun
  );

  modport master (
    output CPOL, CPHA, Endianess, SCLK, SS, MOSI, SendData, SendLoad,
    input  MISO, MISOEn, TxReady, ReceivedData, WordFlg, Busy, Underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer plus history flop; rise/fall are valid in the
// cycle after the synchronized level changes.
module spi_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;
  logic                  level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], din};
      hist_q <= sync_q[SyncStages-1];
    end
  end

  assign level = sync_q[SyncStages-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;
endmodule

// File: rtl/generic_slave_spi.sv
// SPI slave: oversampled SCLK/SS/MOSI, all four CPOL/CPHA modes, either bit
// order, single-word tx holding register with underrun reporting.
module generic_slave_spi
  import spi_pkg::*;
#(
  parameter int unsigned WordLen    = 8,
  parameter int unsigned SyncStages = 2
) (
  input logic                clk,
  input logic                reset,
  generic_slave_spi_if.slave bus
);
  localparam int unsigned        CNT_W    = $clog2(WordLen);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WordLen - 1);

  spi_state_e            state;
  logic                  cpol_q, cpha_q, endian_q;
  logic [WordLen-1:0]    tx_sh, rx_sh, hold, received;
  logic [CNT_W-1:0]      bitcnt;
  logic                  present_pending;
  logic                  tx_ready, miso, miso_en, word_flg, busy, underrun;
  logic [SyncStages-1:0] mosi_sync;

  logic               sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic               leading, trailing, sample_edge, shift_edge;
  logic               mosi_bit, load_accept, reload;
  logic [WordLen-1:0] rx_next, tx_shifted, reload_word;

  spi_sync_edge #(.SyncStages(SyncStages)) u_sclk (
    .clk(clk), .reset(reset), .din(bus.SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SyncStages(SyncStages)) u_ss (
    .clk(clk), .reset(reset), .din(bus.SS), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SyncStages-2:0], bus.MOSI};
  end

  function automatic logic head(input logic [WordLen-1:0] w, input logic endian);
    return (endian == LSB_FIRST) ? w[0] : w[WordLen-1];
  endfunction

  always_comb begin
    leading     = cpol_q ? sclk_fall : sclk_rise;
    trailing    = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trailing : leading;
    shift_edge  = cpha_q ? leading : trailing;
    mosi_bit    = mosi_sync[SyncStages-1];
    rx_next     = (endian_q == LSB_FIRST) ? {mosi_bit, rx_sh[WordLen-1:1]}
                                          : {rx_sh[WordLen-2:0], mosi_bit};
    tx_shifted  = (endian_q == LSB_FIRST) ? {1'b0, tx_sh[WordLen-1:1]}
                                          : {tx_sh[WordLen-2:0], 1'b0};
    load_accept = bus.SendLoad & tx_ready;
    reload_word = tx_ready ? '0 : hold;
    reload      = ((state == IDLE) && ss_fall) ||
                  ((state == ACTIVE) && !ss_rise && sample_edge && (bitcnt == LAST_BIT));
  end

  // A reload and an accepted SendLoad in the same cycle: the reload sees the
  // old (empty) holding register, the new word lands in it afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cpol_q          <= 1'b0;
      cpha_q          <= 1'b0;
      endian_q        <= 1'b0;
      tx_sh           <= '0;
      rx_sh           <= '0;
      hold            <= '0;
      received        <= '0;
      bitcnt          <= '0;
      present_pending <= 1'b0;
      tx_ready        <= 1'b1;
      miso            <= 1'b0;
      miso_en         <= 1'b0;
      word_flg        <= 1'b0;
      busy            <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      word_flg <= 1'b0;
      underrun <= 1'b0;
      if (load_accept) hold <= bus.SendData;
      if (load_accept)  tx_ready <= 1'b0;
      else if (reload)  tx_ready <= 1'b1;

      case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_en <= 1'b0;
          busy    <= 1'b0;
          bitcnt  <= '0;
          if (ss_fall) begin
            state           <= ACTIVE;
            cpol_q          <= bus.CPOL;
            cpha_q          <= bus.CPHA;
            endian_q        <= bus.Endianess;
            miso_en         <= 1'b1;
            busy            <= 1'b1;
            rx_sh           <= '0;
            tx_sh           <= reload_word;
            underrun        <= tx_ready;
            present_pending <= bus.CPHA;
            miso            <= bus.CPHA ? 1'b0 : head(reload_word, bus.Endianess);
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_en <= 1'b0;
            busy    <= 1'b0;
            bitcnt  <= '0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (bitcnt == LAST_BIT) begin
              received        <= rx_next;
              word_flg        <= 1'b1;
              bitcnt          <= '0;
              tx_sh           <= reload_word;
              underrun        <= tx_ready;
              present_pending <= 1'b1;
            end else begin
              bitcnt <= bitcnt + CNT_W'(1);
            end
          end else if (shift_edge) begin
            // First shift edge of a word only presents the head bit.
            if (present_pending) begin
              miso            <= head(tx_sh, endian_q);
              present_pending <= 1'b0;
            end else begin
              tx_sh <= tx_shifted;
              miso  <= head(tx_shifted, endian_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MISO         = miso;
  assign bus.MISOEn       = miso_en;
  assign bus.TxReady      = tx_ready;
  assign bus.ReceivedData = received;
  assign bus.WordFlg      = word_flg;
  assign bus.Busy         = busy;
  assign bus.Underrun     = underrun;
endmodule

// File: tb/tb_generic_slave_spi.sv
// Bench for generic_slave_spi: behavioural SPI master, receive scoreboard,
// vector table plus hand-written multi-word, fragment and reset sequences.
module tb_generic_slave_spi;
  import spi_pkg::*;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       endian;
    logic       load_en;
    logic [7:0] load_w;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   wf_cnt = 0;
  int   ur_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mon_exp;
  vec_t vecs[6];

  generic_slave_spi_if #(.WordLen(8)) bus ();

  generic_slave_spi #(.WordLen(8), .SyncStages(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.WordFlg) begin
      wf_cnt++;
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wordflg: got data 0x%0h, expected no word", bus.ReceivedData);
      end else begin
        mon_exp = rx_q.pop_front();
        check("received_data", {24'd0, bus.ReceivedData}, {24'd0, mon_exp});
      end
    end
    if (!reset && bus.Underrun) ur_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input logic do_load, input logic [7:0] w);
    if (do_load) begin
      bus.SendData = w;
      bus.SendLoad = 1'b1;
      tick(1);
      bus.SendLoad = 1'b0;
      check("txready_after_load", {31'd0, bus.TxReady}, 32'd0);
      tick(4);
    end else begin
      tick(5);
    end
  endtask

  task automatic load(input logic [7:0] w);
    bus.SendData = w;
    bus.SendLoad = 1'b1;
    tick(1);
    bus.SendLoad = 1'b0;
    check("txready_after_preload", {31'd0, bus.TxReady}, 32'd0);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic endian);
    bus.CPOL      = cpol;
    bus.CPHA      = cpha;
    bus.Endianess = endian;
    bus.SCLK      = cpol;
    tick(6);
  endtask

  // Master side of one word (or nbits of it); MISO is sampled on the master's sample edge.
  task automatic xfer(input logic cpol, input logic cpha, input logic endian,
                      input logic [7:0] mosi_w, input int nbits, input int load_bit,
                      input logic [7:0] load_w, output logic [7:0] miso_w);
    logic b;
    miso_w = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = (endian == LSB_FIRST) ? mosi_w[i] : mosi_w[7-i];
      if (!cpha) begin
        bus.MOSI = b;
        half(i == load_bit, load_w);
        miso_w = (endian == LSB_FIRST) ? {bus.MISO, miso_w[7:1]} : {miso_w[6:0], bus.MISO};
        bus.SCLK = ~cpol;
        tick(5);
        bus.SCLK = cpol;
      end else begin
        bus.SCLK = ~cpol;
        bus.MOSI = b;
        half(i == load_bit, load_w);
        miso_w = (endian == LSB_FIRST) ? {bus.MISO, miso_w[7:1]} : {miso_w[6:0], bus.MISO};
        bus.SCLK = cpol;
        tick(5);
      end
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int ur0, wf0;
    logic [7:0] m;
    set_mode(v.cpol, v.cpha, v.endian);
    if (v.load_en) load(v.load_w);
    ur0 = ur_cnt;
    wf0 = wf_cnt;
    rx_q.push_back(v.mosi_w);
    bus.SS = 1'b0;
    tick(6);
    check($sformatf("v%0d_busy", idx), {31'd0, bus.Busy}, 32'd1);
    check($sformatf("v%0d_misoen", idx), {31'd0, bus.MISOEn}, 32'd1);
    check($sformatf("v%0d_txready_start", idx), {31'd0, bus.TxReady}, 32'd1);
    check($sformatf("v%0d_underrun_start", idx), ur_cnt - ur0, v.load_en ? 32'd0 : 32'd1);
    xfer(v.cpol, v.cpha, v.endian, v.mosi_w, 8, -1, 8'h00, m);
    check($sformatf("v%0d_miso_word", idx), {24'd0, m}, {24'd0, v.exp_miso});
    tick(2);
    bus.SS = 1'b1;
    tick(6);
    check($sformatf("v%0d_idle_busy", idx), {31'd0, bus.Busy}, 32'd0);
    check($sformatf("v%0d_idle_misoen", idx), {31'd0, bus.MISOEn}, 32'd0);
    check($sformatf("v%0d_idle_miso", idx), {31'd0, bus.MISO}, 32'd0);
    check($sformatf("v%0d_wordflg_count", idx), wf_cnt - wf0, 32'd1);
    check($sformatf("v%0d_rxdata_hold", idx), {24'd0, bus.ReceivedData}, {24'd0, v.mosi_w});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},     {31'd0, bus.MISO},         32'd0);
    check({tag, "_misoen"},   {31'd0, bus.MISOEn},       32'd0);
    check({tag, "_txready"},  {31'd0, bus.TxReady},      32'd1);
    check({tag, "_rxdata"},   {24'd0, bus.ReceivedData}, 32'd0);
    check({tag, "_wordflg"},  {31'd0, bus.WordFlg},      32'd0);
    check({tag, "_busy"},     {31'd0, bus.Busy},         32'd0);
    check({tag, "_underrun"}, {31'd0, bus.Underrun},     32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m1, m2;
    int wf0;

    vecs[0] = '{1'b0, 1'b0, MSB_FIRST, 1'b1, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, LSB_FIRST, 1'b1, 8'h7E, 8'h81, 8'h7E};
    vecs[2] = '{1'b0, 1'b0, MSB_FIRST, 1'b0, 8'h00, 8'hC3, 8'h00};
    vecs[3] = '{1'b0, 1'b1, MSB_FIRST, 1'b1, 8'h96, 8'h0F, 8'h96};
    vecs[4] = '{1'b1, 1'b0, LSB_FIRST, 1'b1, 8'h01, 8'hF0, 8'h01};
    vecs[5] = '{1'b1, 1'b1, MSB_FIRST, 1'b1, 8'hE7, 8'h6B, 8'hE7};

    reset         = 1'b1;
    bus.SS        = 1'b1;
    bus.SCLK      = 1'b0;
    bus.MOSI      = 1'b0;
    bus.CPOL      = 1'b0;
    bus.CPHA      = 1'b0;
    bus.Endianess = 1'b0;
    bus.SendData  = 8'h00;
    bus.SendLoad  = 1'b0;
    tick(4);
    check_reset_values("reset");
    reset = 1'b0;
    tick(4);

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // Two back-to-back words under one SS, second word loaded mid-way through the first.
    for (int k = 0; k < 2; k++) begin
      set_mode(k == 0 ? 1'b0 : 1'b1, k == 0 ? 1'b1 : 1'b0, k == 0 ? MSB_FIRST : LSB_FIRST);
      load(8'hC5);
      wf0 = wf_cnt;
      rx_q.push_back(8'h3A);
      rx_q.push_back(8'h9D);
      bus.SS = 1'b0;
      tick(6);
      xfer(bus.CPOL, bus.CPHA, bus.Endianess, 8'h3A, 8, 3, 8'h6E, m1);
      check($sformatf("dual%0d_miso_w1", k), {24'd0, m1}, 32'hC5);
      check($sformatf("dual%0d_txready_reload", k), {31'd0, bus.TxReady}, 32'd1);
      xfer(bus.CPOL, bus.CPHA, bus.Endianess, 8'h9D, 8, -1, 8'h00, m2);
      check($sformatf("dual%0d_miso_w2", k), {24'd0, m2}, 32'h6E);
      tick(2);
      bus.SS = 1'b1;
      tick(6);
      check($sformatf("dual%0d_wordflg_count", k), wf_cnt - wf0, 32'd2);
    end

    // Fragment of 3 bits dropped, then a full word.
    set_mode(1'b0, 1'b0, MSB_FIRST);
    load(8'h11);
    wf0 = wf_cnt;
    bus.SS = 1'b0;
    tick(6);
    xfer(1'b0, 1'b0, MSB_FIRST, 8'hFF, 3, -1, 8'h00, m1);
    bus.SS = 1'b1;
    tick(6);
    check("fragment_wordflg_count", wf_cnt - wf0, 32'd0);
    run_vector('{1'b0, 1'b0, MSB_FIRST, 1'b1, 8'h22, 8'h5A, 8'h22}, 10);

    // Reset pulse in the middle of a word.
    set_mode(1'b0, 1'b0, MSB_FIRST);
    load(8'h44);
    wf0 = wf_cnt;
    bus.SS = 1'b0;
    tick(6);
    fork
      xfer(1'b0, 1'b0, MSB_FIRST, 8'h77, 8, -1, 8'h00, m1);
      begin
        tick(35);
        reset = 1'b1;
        tick(1);
        check_reset_values("midword_reset");
        reset = 1'b0;
      end
    join
    bus.SS = 1'b1;
    tick(6);
    check("reset_word_dropped", wf_cnt - wf0, 32'd0);
    run_vector('{1'b0, 1'b0, MSB_FIRST, 1'b1, 8'hB4, 8'h5A, 8'hB4}, 11);

    for (int t = 0; t < 100 && rx_q.size() != 0; t++) tick(1);
    check("scoreboard_empty", rx_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
